// File: rtl/lsu_align_pkg.sv
// Shared types and helpers for the load/store alignment unit.
package lsu_align_pkg;

    // Access size encoded as log2 of the byte count.
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } size_e;

    // Control FSM states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE_LO = 3'd1,
        ST_WAIT_LO  = 3'd2,
        ST_ISSUE_HI = 3'd3,
        ST_WAIT_HI  = 3'd4,
        ST_RESPOND  = 3'd5
    } state_e;

    // Number of bytes touched by an access of the given size.
    function automatic int unsigned size_bytes(input size_e size);
        return 32'd1 << size;
    endfunction

    // An access is split when its last byte falls into the next bus word.
    function automatic logic calc_split(input logic [3:0] off, input size_e size,
                                        input int unsigned lanes);
        return (32'(off) + size_bytes(size)) > lanes;
    endfunction

endpackage

// File: rtl/lsu_align_unit_lane_gen.sv
// Combinational lane steering: byte enables and shifted store data for both
// beats of an access, derived from the byte offset and size.
module lsu_lane_gen
    import lsu_align_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int B          = DATA_WIDTH / 8,
    parameter int OFFW       = $clog2(B)
) (
    input  logic [OFFW-1:0]       i_off,
    input  size_e                 i_size,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [B-1:0]          o_be_lo,
    output logic [B-1:0]          o_be_hi,
    output logic [DATA_WIDTH-1:0] o_wdata_lo,
    output logic [DATA_WIDTH-1:0] o_wdata_hi
);

    logic [B-1:0]            mask_b;
    logic [2*B-1:0]          be_sh;
    logic [2*DATA_WIDTH-1:0] wd_sh;
    int unsigned             n;

    // Shift the size mask and data across a double-width window; the upper
    // half of the window is exactly what spills into the high beat.
    always_comb begin
        n      = size_bytes(i_size);
        mask_b = '0;
        for (int unsigned i = 0; i < B; i++) begin
            mask_b[i] = (i < n);
        end
        be_sh      = {{B{1'b0}}, mask_b} << i_off;
        wd_sh      = {{DATA_WIDTH{1'b0}}, i_wdata} << {i_off, 3'b000};
        o_be_lo    = be_sh[B-1:0];
        o_be_hi    = be_sh[2*B-1:B];
        o_wdata_lo = wd_sh[DATA_WIDTH-1:0];
        o_wdata_hi = wd_sh[2*DATA_WIDTH-1:DATA_WIDTH];
    end

endmodule

// File: rtl/lsu_align_unit.sv
// Load/store alignment unit: turns one core access into one or two aligned
// bus beats and returns extended load data with a single completion pulse.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; while valid is high and ready is low, the sender holds every
// payload signal stable. o_rsp_valid and i_bus_rvalid are unconditioned
// one-cycle pulses with no backpressure.
module lsu_align_unit
    import lsu_align_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [1:0]              i_req_size,
    input  logic                    i_req_unsigned,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    output logic                    o_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                    o_rsp_misaligned,
    output logic                    o_bus_valid,
    input  logic                    i_bus_ready,
    output logic                    o_bus_we,
    output logic [ADDR_WIDTH-1:0]   o_bus_addr,
    output logic [DATA_WIDTH/8-1:0] o_bus_be,
    output logic [DATA_WIDTH-1:0]   o_bus_wdata,
    input  logic                    i_bus_rvalid,
    input  logic [DATA_WIDTH-1:0]   i_bus_rdata,
    output state_e                  o_dbg_state
);

    localparam int B    = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(B);

    state_e                state_q, state_d;
    logic                  req_we_q, req_we_d;
    size_e                 req_size_q, req_size_d;
    logic                  req_unsigned_q, req_unsigned_d;
    logic [OFFW-1:0]       req_off_q, req_off_d;
    logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
    logic                  split_q, split_d;
    logic [DATA_WIDTH-1:0] lo_data_q, lo_data_d;
    logic [DATA_WIDTH-1:0] hi_data_q, hi_data_d;
    logic                  bus_valid_q, bus_valid_d;
    logic                  bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [B-1:0]          bus_be_q, bus_be_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_mis_q, rsp_mis_d;

    // Lane generator looks at the incoming request while idle (so the first
    // beat can be registered on the accept edge) and at the latched one after.
    logic                  idle;
    logic [OFFW-1:0]       lg_off;
    size_e                 lg_size;
    logic [DATA_WIDTH-1:0] lg_wdata;
    logic [B-1:0]          be_lo, be_hi;
    logic [DATA_WIDTH-1:0] wdata_lo, wdata_hi;
    logic                  split_in;
    logic [ADDR_WIDTH-1:0] lo_addr_in;

    // Select lane-generator inputs and precompute incoming-request properties.
    always_comb begin
        idle       = (state_q == ST_IDLE);
        lg_off     = idle ? i_req_addr[OFFW-1:0] : req_off_q;
        lg_size    = idle ? size_e'(i_req_size) : req_size_q;
        lg_wdata   = idle ? i_req_wdata : req_wdata_q;
        split_in   = calc_split({{(4-OFFW){1'b0}}, i_req_addr[OFFW-1:0]},
                                size_e'(i_req_size), B);
        lo_addr_in = {i_req_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
    end

    lsu_lane_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lane_gen (
        .i_off      (lg_off),
        .i_size     (lg_size),
        .i_wdata    (lg_wdata),
        .o_be_lo    (be_lo),
        .o_be_hi    (be_hi),
        .o_wdata_lo (wdata_lo),
        .o_wdata_hi (wdata_hi)
    );

    logic [DATA_WIDTH-1:0] rd_lo_src, rd_hi_src, rd_shift, rd_ext;
    int unsigned           rd_n;
    logic                  sign_bit;

    // Load extraction: the returning beat is used directly so the response
    // can be registered in the same cycle the data arrives.
    always_comb begin
        rd_lo_src = (state_q == ST_WAIT_LO) ? i_bus_rdata : lo_data_q;
        rd_hi_src = (state_q == ST_WAIT_HI) ? i_bus_rdata : hi_data_q;
        rd_shift  = DATA_WIDTH'({rd_hi_src, rd_lo_src} >> {req_off_q, 3'b000});
        rd_n      = size_bytes(req_size_q);
        sign_bit  = 1'b0;
        for (int unsigned i = 0; i < B; i++) begin
            if (i == rd_n - 1) begin
                sign_bit = rd_shift[8*i+7];
            end
        end
        rd_ext = '0;
        for (int unsigned i = 0; i < B; i++) begin
            if (i < rd_n) begin
                rd_ext[8*i +: 8] = rd_shift[8*i +: 8];
            end else begin
                rd_ext[8*i +: 8] = {8{sign_bit & ~req_unsigned_q}};
            end
        end
    end

    // Next-state and next-output logic of the control FSM.
    always_comb begin
        state_d        = state_q;
        req_we_d       = req_we_q;
        req_size_d     = req_size_q;
        req_unsigned_d = req_unsigned_q;
        req_off_d      = req_off_q;
        req_wdata_d    = req_wdata_q;
        split_d        = split_q;
        lo_data_d      = lo_data_q;
        hi_data_d      = hi_data_q;
        bus_valid_d    = bus_valid_q;
        bus_we_d       = bus_we_q;
        bus_addr_d     = bus_addr_q;
        bus_be_d       = bus_be_q;
        bus_wdata_d    = bus_wdata_q;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_mis_d      = rsp_mis_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    req_we_d       = i_req_we;
                    req_size_d     = size_e'(i_req_size);
                    req_unsigned_d = i_req_unsigned;
                    req_off_d      = i_req_addr[OFFW-1:0];
                    req_wdata_d    = i_req_wdata;
                    split_d        = split_in;
                    if (split_in && !ALLOW_MISALIGNED) begin
                        state_d     = ST_RESPOND;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_mis_d   = 1'b1;
                    end else begin
                        state_d     = ST_ISSUE_LO;
                        bus_valid_d = 1'b1;
                        bus_we_d    = i_req_we;
                        bus_addr_d  = lo_addr_in;
                        bus_be_d    = be_lo;
                        bus_wdata_d = wdata_lo;
                    end
                end
            end
            ST_ISSUE_LO: begin
                if (i_bus_ready) begin
                    if (!req_we_q) begin
                        state_d     = ST_WAIT_LO;
                        bus_valid_d = 1'b0;
                    end else if (split_q) begin
                        state_d     = ST_ISSUE_HI;
                        bus_addr_d  = bus_addr_q + ADDR_WIDTH'(B);
                        bus_be_d    = be_hi;
                        bus_wdata_d = wdata_hi;
                    end else begin
                        state_d     = ST_RESPOND;
                        bus_valid_d = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_mis_d   = 1'b0;
                    end
                end
            end
            ST_WAIT_LO: begin
                if (i_bus_rvalid) begin
                    lo_data_d = i_bus_rdata;
                    if (split_q) begin
                        state_d     = ST_ISSUE_HI;
                        bus_valid_d = 1'b1;
                        bus_addr_d  = bus_addr_q + ADDR_WIDTH'(B);
                        bus_be_d    = be_hi;
                        bus_wdata_d = wdata_hi;
                    end else begin
                        state_d     = ST_RESPOND;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = rd_ext;
                        rsp_mis_d   = 1'b0;
                    end
                end
            end
            ST_ISSUE_HI: begin
                if (i_bus_ready) begin
                    bus_valid_d = 1'b0;
                    if (!req_we_q) begin
                        state_d = ST_WAIT_HI;
                    end else begin
                        state_d     = ST_RESPOND;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_mis_d   = 1'b0;
                    end
                end
            end
            ST_WAIT_HI: begin
                if (i_bus_rvalid) begin
                    hi_data_d   = i_bus_rdata;
                    state_d     = ST_RESPOND;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rd_ext;
                    rsp_mis_d   = 1'b0;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= ST_IDLE;
            req_we_q       <= 1'b0;
            req_size_q     <= SIZE_B;
            req_unsigned_q <= 1'b0;
            req_off_q      <= '0;
            req_wdata_q    <= '0;
            split_q        <= 1'b0;
            lo_data_q      <= '0;
            hi_data_q      <= '0;
            bus_valid_q    <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_addr_q     <= '0;
            bus_be_q       <= '0;
            bus_wdata_q    <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_mis_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_we_q       <= req_we_d;
            req_size_q     <= req_size_d;
            req_unsigned_q <= req_unsigned_d;
            req_off_q      <= req_off_d;
            req_wdata_q    <= req_wdata_d;
            split_q        <= split_d;
            lo_data_q      <= lo_data_d;
            hi_data_q      <= hi_data_d;
            bus_valid_q    <= bus_valid_d;
            bus_we_q       <= bus_we_d;
            bus_addr_q     <= bus_addr_d;
            bus_be_q       <= bus_be_d;
            bus_wdata_q    <= bus_wdata_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_mis_q      <= rsp_mis_d;
        end
    end

    assign o_req_ready      = idle;
    assign o_rsp_valid      = rsp_valid_q;
    assign o_rsp_rdata      = rsp_rdata_q;
    assign o_rsp_misaligned = rsp_mis_q;
    assign o_bus_valid      = bus_valid_q;
    assign o_bus_we         = bus_we_q;
    assign o_bus_addr       = bus_addr_q;
    assign o_bus_be         = bus_be_q;
    assign o_bus_wdata      = bus_wdata_q;
    assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_lsu_align_unit.sv
// Directed bench for lsu_align_unit: a vector table of single accesses plus
// hand-written backpressure, fault and mid-operation reset sequences.
module tb_lsu_align_unit;
    import lsu_align_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int B  = DW / 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0, req_we = 1'b0, req_uns = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          bus_ready = 1'b1, bus_rvalid = 1'b0;
    logic [DW-1:0] bus_rdata = '0;

    logic          req_ready, rsp_valid, rsp_mis, bus_valid, bus_we;
    logic [DW-1:0] rsp_rdata, bus_wdata;
    logic [AW-1:0] bus_addr;
    logic [B-1:0]  bus_be;
    state_e        dbg_state;

    logic          f_req_ready, f_rsp_valid, f_rsp_mis, f_bus_valid, f_bus_we;
    logic [DW-1:0] f_rsp_rdata, f_bus_wdata;
    logic [AW-1:0] f_bus_addr;
    logic [B-1:0]  f_bus_be;
    state_e        f_dbg_state;

    lsu_align_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALLOW_MISALIGNED(1'b1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_size(req_size), .i_req_unsigned(req_uns), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_misaligned(rsp_mis),
        .o_bus_valid(bus_valid), .i_bus_ready(bus_ready), .o_bus_we(bus_we),
        .o_bus_addr(bus_addr), .o_bus_be(bus_be), .o_bus_wdata(bus_wdata),
        .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata),
        .o_dbg_state(dbg_state)
    );

    // Faulting variant shares all inputs; only its outputs are checked.
    lsu_align_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALLOW_MISALIGNED(1'b0)) dut_f (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(f_req_ready), .i_req_we(req_we),
        .i_req_size(req_size), .i_req_unsigned(req_uns), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata),
        .o_rsp_valid(f_rsp_valid), .o_rsp_rdata(f_rsp_rdata), .o_rsp_misaligned(f_rsp_mis),
        .o_bus_valid(f_bus_valid), .i_bus_ready(bus_ready), .o_bus_we(f_bus_we),
        .o_bus_addr(f_bus_addr), .o_bus_be(f_bus_be), .o_bus_wdata(f_bus_wdata),
        .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata),
        .o_dbg_state(f_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd_lo;
        logic [31:0] rd_hi;
        int          nbeats;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] w0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] w1;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        bus_rvalid = 1'b0;
        bus_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_uns   = uns;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    // Apply one access with ready high, act as the bus slave, check beats,
    // response data and latency (k counts cycles after the accept cycle).
    task automatic run_txn(input vec_t v, input string tag);
        int   k;
        int   beat;
        int   pend_beat;
        bit   pend;
        bit   done;
        logic [DW-1:0] exp_rd;
        @(negedge clk);
        bus_ready = 1'b1;
        drive_req(v.we, v.size, v.uns, v.addr, v.wdata);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        exp_q.push_back(v.rdata);
        @(negedge clk);
        req_valid = 1'b0;
        k = 1; beat = 0; pend = 1'b0; pend_beat = 0; done = 1'b0;
        while (!done && k < 40) begin
            bus_rvalid = 1'b0;
            if (pend) begin
                bus_rvalid = 1'b1;
                bus_rdata  = (pend_beat == 0) ? v.rd_lo : v.rd_hi;
                pend = 1'b0;
            end
            if (bus_valid) begin
                if (beat == 0) begin
                    check({tag, "_addr0"}, 64'(bus_addr), 64'(v.a0));
                    check({tag, "_be0"}, 64'(bus_be), 64'(v.be0));
                    if (v.we) check({tag, "_wdata0"}, 64'(bus_wdata), 64'(v.w0));
                end else if (beat == 1) begin
                    check({tag, "_addr1"}, 64'(bus_addr), 64'(v.a1));
                    check({tag, "_be1"}, 64'(bus_be), 64'(v.be1));
                    if (v.we) check({tag, "_wdata1"}, 64'(bus_wdata), 64'(v.w1));
                end
                check({tag, "_bus_we"}, 64'(bus_we), 64'(v.we));
                if (!v.we) begin
                    pend = 1'b1;
                    pend_beat = beat;
                end
                beat++;
            end
            if (rsp_valid) begin
                exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                check({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
                check({tag, "_mis"}, 64'(rsp_mis), 64'd0);
                check({tag, "_latency"}, 64'(k), 64'(v.lat));
                check({tag, "_beats"}, 64'(beat), 64'(v.nbeats));
                done = 1'b1;
            end
            @(negedge clk);
            k++;
        end
        bus_rvalid = 1'b0;
        if (!done) begin
            fail_now({tag, "_rsp_timeout"});
            void'(exp_q.pop_front());
        end
        check({tag, "_rsp_one_cycle"}, 64'(rsp_valid), 64'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        //          we    sz     uns   addr           wdata          rd_lo          rd_hi          nb a0             be0      w0             a1             be1      w1             rdata          lat
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         32'h0,         1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0,         4'b0000, 32'h0,         32'h0,         2};
        vecs[1]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_00A5, 32'h0,         32'h0,         1, 32'h0000_0100, 4'b1000, 32'hA500_0000, 32'h0,         4'b0000, 32'h0,         32'h0,         2};
        vecs[2]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0102, 32'h1122_3344, 32'h0,         32'h0,         2, 32'h0000_0100, 4'b1100, 32'h3344_0000, 32'h0000_0104, 4'b0011, 32'h0000_1122, 32'h0,         3};
        vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0203, 32'h0,         32'h8A00_0000, 32'h0000_00F1, 2, 32'h0000_0200, 4'b1000, 32'h0,         32'h0000_0204, 4'b0001, 32'h0,         32'hFFFF_F18A, 5};
        vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0203, 32'h0,         32'h8A00_0000, 32'h0000_00F1, 2, 32'h0000_0200, 4'b1000, 32'h0,         32'h0000_0204, 4'b0001, 32'h0,         32'h0000_F18A, 5};
        vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0,         32'h8000_0001, 32'h0,         1, 32'h0000_0300, 4'b1111, 32'h0,         32'h0,         4'b0000, 32'h0,         32'h8000_0001, 3};
        vecs[6]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0301, 32'h0,         32'h1234_8056, 32'h0,         1, 32'h0000_0300, 4'b0010, 32'h0,         32'h0,         4'b0000, 32'h0,         32'hFFFF_FF80, 3};
        vecs[7]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0302, 32'h0,         32'h1234_8056, 32'h0,         1, 32'h0000_0300, 4'b0100, 32'h0,         32'h0,         4'b0000, 32'h0,         32'h0000_0034, 3};
        vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0302, 32'h0,         32'hBEEF_1234, 32'h0,         1, 32'h0000_0300, 4'b1100, 32'h0,         32'h0,         4'b0000, 32'h0,         32'hFFFF_BEEF, 3};
        vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0101, 32'h0000_CAFE, 32'h0,         32'h0,         1, 32'h0000_0100, 4'b0110, 32'h00CA_FE00, 32'h0,         4'b0000, 32'h0,         32'h0,         2};
        vecs[10] = '{1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h5566_7788, 32'h0,         32'h0,         2, 32'hFFFF_FFFC, 4'b1100, 32'h7788_0000, 32'h0000_0000, 4'b0011, 32'h0000_5566, 32'h0,         3};
        vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h0000_0105, 32'h0,         32'hAABB_CCDD, 32'h1122_3344, 2, 32'h0000_0104, 4'b1110, 32'h0,         32'h0000_0108, 4'b0001, 32'h0,         32'h44AA_BBCC, 5};

        // Reset state.
        do_reset();
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        check("rst_bus_valid", 64'(bus_valid), 64'd0);
        check("rst_bus_we", 64'(bus_we), 64'd0);
        check("rst_bus_addr", 64'(bus_addr), 64'd0);
        check("rst_bus_be", 64'(bus_be), 64'd0);
        check("rst_bus_wdata", 64'(bus_wdata), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_mis", 64'(rsp_mis), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);

        // Table-driven single accesses.
        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure on a split store: ready low for three cycles.
        begin
            int got_rsp;
            @(negedge clk);
            bus_ready = 1'b0;
            drive_req(1'b1, 2'd2, 1'b0, 32'h0000_0102, 32'h1122_3344);
            @(negedge clk);
            req_valid = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                check($sformatf("bp_valid_k%0d", k), 64'(bus_valid), 64'd1);
                check($sformatf("bp_addr_k%0d", k), 64'(bus_addr), 64'h100);
                check($sformatf("bp_be_k%0d", k), 64'(bus_be), 64'hC);
                check($sformatf("bp_wdata_k%0d", k), 64'(bus_wdata), 64'h3344_0000);
                check($sformatf("bp_req_ready_k%0d", k), 64'(req_ready), 64'd0);
                if (k == 3) bus_ready = 1'b1;
                @(negedge clk);
            end
            check("bp_beat1_valid", 64'(bus_valid), 64'd1);
            check("bp_beat1_addr", 64'(bus_addr), 64'h104);
            check("bp_beat1_be", 64'(bus_be), 64'h3);
            check("bp_beat1_wdata", 64'(bus_wdata), 64'h0000_1122);
            @(negedge clk);
            got_rsp = 0;
            for (int k = 0; k < 10 && got_rsp == 0; k++) begin
                if (rsp_valid) got_rsp = 1;
                else @(negedge clk);
            end
            if (got_rsp == 0) fail_now("bp_rsp_timeout");
            else check("bp_rsp_mis", 64'(rsp_mis), 64'd0);
        end

        // Fault path on the non-splitting instance: LW at 0x101.
        do_reset();
        begin
            int f_beats;
            f_beats = 0;
            @(negedge clk);
            drive_req(1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0);
            check("flt_req_ready", 64'(f_req_ready), 64'd1);
            @(negedge clk);
            req_valid = 1'b0;
            if (f_bus_valid) f_beats++;
            check("flt_rsp_valid_t1", 64'(f_rsp_valid), 64'd1);
            check("flt_rsp_mis", 64'(f_rsp_mis), 64'd1);
            check("flt_rsp_rdata", 64'(f_rsp_rdata), 64'd0);
            @(negedge clk);
            if (f_bus_valid) f_beats++;
            check("flt_rsp_valid_t2", 64'(f_rsp_valid), 64'd0);
            check("flt_idle_t2", 64'(f_req_ready), 64'd1);
            @(negedge clk);
            if (f_bus_valid) f_beats++;
            check("flt_no_bus_beat", 64'(f_beats), 64'd0);
        end

        // Reset during WAIT_HI of a split load, then a late rvalid.
        do_reset();
        begin
            int rsp_seen;
            rsp_seen = 0;
            @(negedge clk);
            bus_ready = 1'b1;
            drive_req(1'b0, 2'd1, 1'b0, 32'h0000_0203, 32'h0);
            @(negedge clk);                  // k=1: beat 0 handshake pending
            req_valid = 1'b0;
            check("rwh_beat0_valid", 64'(bus_valid), 64'd1);
            @(negedge clk);                  // k=2: WAIT_LO, deliver low data
            bus_rvalid = 1'b1;
            bus_rdata  = 32'h8A00_0000;
            @(negedge clk);                  // k=3: ISSUE_HI
            bus_rvalid = 1'b0;
            check("rwh_beat1_valid", 64'(bus_valid), 64'd1);
            @(negedge clk);                  // k=4: WAIT_HI
            check("rwh_in_wait_hi", 64'(dbg_state), 64'(ST_WAIT_HI));
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("rwh_state_idle", 64'(dbg_state), 64'(ST_IDLE));
            check("rwh_bus_dropped", 64'(bus_valid), 64'd0);
            bus_rvalid = 1'b1;
            bus_rdata  = 32'h0000_00F1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                bus_rvalid = 1'b0;
                if (rsp_valid) rsp_seen++;
            end
            check("rwh_no_rsp", 64'(rsp_seen), 64'd0);
            check("rwh_final_idle", 64'(dbg_state), 64'(ST_IDLE));
            check("rwh_final_ready", 64'(req_ready), 64'd1);
        end

        // A normal access still completes after the aborted one.
        run_txn(vecs[5], "post_rst");

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time bound expired");
        $fatal(1);
    end

endmodule
